// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared types for the data-memory request controller.
//   lsu_op_type        : one-hot load/store opcode (lb, lh, lw, lbu, lhu, sb, sh, sw)
//   dmem_state_t       : controller FSM states
//   dmem_ctrl_in_type  : request fields coming from execute
//   dmem_ctrl_out_type : registered completion fields handed to load extraction
//   CAUSE_*            : misaligned-access exception cause codes
package dmem_ctrl_pkg;

  typedef struct packed {
    logic lsu_lb;
    logic lsu_lh;
    logic lsu_lw;
    logic lsu_lbu;
    logic lsu_lhu;
    logic lsu_sb;
    logic lsu_sh;
    logic lsu_sw;
  } lsu_op_type;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    lsu_op_type  lsu_op;
  } dmem_ctrl_in_type;

  typedef struct packed {
    logic [31:0] ldata;
    logic [3:0]  byteenable;
    lsu_op_type  lsu_op;
    logic        exc;
    logic [3:0]  ecause;
  } dmem_ctrl_out_type;

  function automatic logic is_store(lsu_op_type op);
    return op.lsu_sb | op.lsu_sh | op.lsu_sw;
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: bundles the execute request, data-memory port and
// completion signals of dmem_ctrl.
//   master : execute/memory side (drives req_*, mem_ready, mem_rdata)
//   slave  : the controller (drives req_ready, mem_*, resp_*)
interface dmem_ctrl_if import dmem_ctrl_pkg::*; ();
  // execute request
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  lsu_op_type  req_lsu_op;
  // data-memory port
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  // completion to load extraction
  logic        resp_valid;
  logic [31:0] resp_ldata;
  logic [3:0]  resp_byteenable;
  lsu_op_type  resp_lsu_op;
  logic        resp_exc;
  logic [3:0]  resp_ecause;

  modport master (
    output req_valid, req_addr, req_wdata, req_lsu_op, mem_ready, mem_rdata,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb,
           resp_valid, resp_ldata, resp_byteenable, resp_lsu_op, resp_exc, resp_ecause
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_lsu_op, mem_ready, mem_rdata,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb,
           resp_valid, resp_ldata, resp_byteenable, resp_lsu_op, resp_exc, resp_ecause
  );
endinterface

// File: rtl/dmem_ctrl_align.sv
// dmem_align: combinational access-shape decode.
//   i_op         : one-hot lsu op
//   i_addr_lo    : address bits [1:0]
//   i_wdata      : right-aligned store data
//   o_byteenable : lane enables (byte/half shifted into place, word = 4'hF)
//   o_wdata      : store data replicated across all lanes of its size
//   o_misalign   : half/word not naturally aligned; only computed when
//                  MISALIGN_EXC_EN is defined, otherwise constant 0
// Without MISALIGN_EXC_EN the half enable uses only addr[1] and the word
// enable ignores addr[1:0], which truncates to natural alignment.
module dmem_align import dmem_ctrl_pkg::*; (
  input  lsu_op_type  i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_byteenable,
  output logic [31:0] o_wdata,
  output logic        o_misalign
);
  logic w_byte, w_half, w_word;

  assign w_byte = i_op.lsu_lb | i_op.lsu_lbu | i_op.lsu_sb;
  assign w_half = i_op.lsu_lh | i_op.lsu_lhu | i_op.lsu_sh;
  assign w_word = i_op.lsu_lw | i_op.lsu_sw;

  always_comb begin
    o_byteenable = 4'h0;
    o_wdata      = i_wdata;
    if (w_byte) begin
      o_byteenable = 4'h1 << i_addr_lo;
      o_wdata      = {4{i_wdata[7:0]}};
    end else if (w_half) begin
      o_byteenable = 4'h3 << {i_addr_lo[1], 1'b0};
      o_wdata      = {2{i_wdata[15:0]}};
    end else if (w_word) begin
      o_byteenable = 4'hF;
    end
  end

`ifdef MISALIGN_EXC_EN
  assign o_misalign = (w_half & i_addr_lo[0]) | (w_word & (|i_addr_lo));
`else
  assign o_misalign = 1'b0;
`endif

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory request controller, one access outstanding.
//   i_clock : rising-edge clock
//   i_reset : synchronous active-low reset
//   bus     : dmem_ctrl_if.slave (execute request, memory port, completion)
// Flow: IDLE accepts a request and registers its shape, BUSY holds
// mem_valid with stable address/data/strobe until mem_ready, RESP pulses
// resp_valid for one cycle. resp_* hold until the next completion.
// Optional feature macro MISALIGN_EXC_EN: misaligned half/word accesses
// skip memory and complete from IDLE straight to RESP with resp_exc set.
// When undefined, resp_exc/resp_ecause are only ever loaded with 0.
module dmem_ctrl import dmem_ctrl_pkg::*; (
  input logic      i_clock,
  input logic      i_reset,
  dmem_ctrl_if.slave bus
);
  dmem_state_t       r_state, w_next;
  dmem_ctrl_in_type  w_req;
  dmem_ctrl_out_type r_resp;
  lsu_op_type        r_op;
  logic [31:0]       r_addr, r_wdata;
  logic [3:0]        r_be;
  logic              r_store;

  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic              w_misalign;
  logic              w_accept;

  assign w_req = '{valid:  bus.req_valid,
                   addr:   bus.req_addr,
                   wdata:  bus.req_wdata,
                   lsu_op: bus.req_lsu_op};

  dmem_align u_align (
    .i_op         (w_req.lsu_op),
    .i_addr_lo    (w_req.addr[1:0]),
    .i_wdata      (w_req.wdata),
    .o_byteenable (w_be),
    .o_wdata      (w_wdata),
    .o_misalign   (w_misalign)
  );

  assign w_accept = (r_state == IDLE) && w_req.valid;

  // state register
  always_ff @(posedge i_clock) begin
    if (!i_reset) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_req.valid) w_next = w_misalign ? RESP : BUSY;
      BUSY:    if (bus.mem_ready) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    bus.req_ready  = (r_state == IDLE);
    bus.mem_valid  = (r_state == BUSY);
    bus.resp_valid = (r_state == RESP);
  end

  // request and completion datapath
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_op    <= '0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_be    <= 4'h0;
      r_store <= 1'b0;
      r_resp  <= '0;
    end else begin
      if (w_accept) begin
        r_op <= w_req.lsu_op;
        if (w_misalign) begin
          // trapped access completes without touching the memory port
          r_resp.ldata      <= 32'h0;
          r_resp.byteenable <= 4'h0;
          r_resp.lsu_op     <= w_req.lsu_op;
          r_resp.exc        <= 1'b1;
          r_resp.ecause     <= is_store(w_req.lsu_op) ? CAUSE_STORE_MISALIGN
                                                      : CAUSE_LOAD_MISALIGN;
        end else begin
          r_addr  <= {w_req.addr[31:2], 2'b00};
          r_wdata <= w_wdata;
          r_be    <= w_be;
          r_store <= is_store(w_req.lsu_op);
        end
      end
      if ((r_state == BUSY) && bus.mem_ready) begin
        r_resp.ldata      <= r_store ? 32'h0 : bus.mem_rdata;
        r_resp.byteenable <= r_be;
        r_resp.lsu_op     <= r_op;
        r_resp.exc        <= 1'b0;
        r_resp.ecause     <= 4'h0;
      end
    end
  end

  assign bus.mem_addr        = r_addr;
  assign bus.mem_wdata       = r_wdata;
  assign bus.mem_wstrb       = r_store ? r_be : 4'h0;
  assign bus.resp_ldata      = r_resp.ldata;
  assign bus.resp_byteenable = r_resp.byteenable;
  assign bus.resp_lsu_op     = r_resp.lsu_op;
  assign bus.resp_exc        = r_resp.exc;
  assign bus.resp_ecause     = r_resp.ecause;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: self-checking bench for dmem_ctrl. Directed scenarios plus
// randomized accesses compared against an arithmetic reference model.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  dmem_ctrl_if bus();

  dmem_ctrl dut (
    .i_clock (clock),
    .i_reset (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          timeout;
    int          lat;
    int          mem_cycles;
    bit          stable;
    bit          ready_low;
    bit          pulse_one;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  mwstrb;
    logic [31:0] ldata;
    logic [3:0]  be;
    lsu_op_type  op;
    logic        exc;
    logic [3:0]  ecause;
  } obs_t;

  // op index: 0 lb, 1 lh, 2 lw, 3 lbu, 4 lhu, 5 sb, 6 sh, 7 sw
  function automatic int op_size(int k);
    case (k)
      0, 3, 5: return 1;
      1, 4, 6: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit op_store(int k);
    return k >= 5;
  endfunction

  function automatic lsu_op_type mk_op(int k);
    lsu_op_type o;
    o = '0;
    case (k)
      0: o.lsu_lb  = 1'b1;
      1: o.lsu_lh  = 1'b1;
      2: o.lsu_lw  = 1'b1;
      3: o.lsu_lbu = 1'b1;
      4: o.lsu_lhu = 1'b1;
      5: o.lsu_sb  = 1'b1;
      6: o.lsu_sh  = 1'b1;
      default: o.lsu_sw = 1'b1;
    endcase
    return o;
  endfunction

  function automatic bit model_trap(int k, logic [31:0] a);
`ifdef MISALIGN_EXC_EN
    return (a % op_size(k)) != 0;
`else
    return (k < 0) && (a == 0);
`endif
  endfunction

  // lane offset truncated down to a multiple of the access size
  function automatic logic [3:0] model_be(int k, logic [31:0] a);
    int sz, off;
    sz  = op_size(k);
    off = (int'(a % 4) / sz) * sz;
    return 4'(((1 << sz) - 1) << off);
  endfunction

  function automatic logic [31:0] model_wdata(int k, logic [31:0] w);
    logic [31:0] b, h;
    b = {24'h0, w[7:0]};
    h = {16'h0, w[15:0]};
    case (op_size(k))
      1:       return b * 32'h01010101;
      2:       return h * 32'h00010001;
      default: return w;
    endcase
  endfunction

  // Drives one access from IDLE and records what the DUT did; no checking.
  task automatic run_access(input int k, input logic [31:0] a, input logic [31:0] w,
                            input logic [31:0] rd, input int delay, input bit hold,
                            output obs_t o);
    int waited;
    logic [31:0] l_ld;
    logic [3:0]  l_be;
    lsu_op_type  l_op;
    logic        l_exc;
    logic [3:0]  l_ec;
    o.timeout = 0; o.lat = 0; o.mem_cycles = 0; o.stable = 1; o.ready_low = 1;
    o.pulse_one = 0; o.maddr = 0; o.mwdata = 0; o.mwstrb = 0;
    waited = 0;
    bus.req_valid  = 1'b1;
    bus.req_addr   = a;
    bus.req_wdata  = w;
    bus.req_lsu_op = mk_op(k);
    @(posedge clock); o.lat = 1;
    @(negedge clock);
    bus.req_valid  = hold;
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    bus.req_lsu_op = mk_op($urandom_range(0, 7));
    while (bus.resp_valid !== 1'b1 && o.lat < 40) begin
      if (bus.req_ready !== 1'b0) o.ready_low = 0;
      if (bus.mem_valid === 1'b1) begin
        if (o.mem_cycles == 0) begin
          o.maddr = bus.mem_addr; o.mwdata = bus.mem_wdata; o.mwstrb = bus.mem_wstrb;
        end else if (o.maddr !== bus.mem_addr || o.mwdata !== bus.mem_wdata ||
                     o.mwstrb !== bus.mem_wstrb) begin
          o.stable = 0;
        end
        o.mem_cycles++;
        if (waited < delay) begin
          bus.mem_ready = 1'b0; bus.mem_rdata = $urandom; waited++;
        end else begin
          bus.mem_ready = 1'b1; bus.mem_rdata = rd;
        end
      end
      @(posedge clock); o.lat++;
      @(negedge clock);
      bus.mem_ready = 1'b0;
      bus.mem_rdata = $urandom;
    end
    o.timeout = (bus.resp_valid !== 1'b1);
    if (bus.req_ready !== 1'b0) o.ready_low = 0;
    o.ldata = bus.resp_ldata; o.be = bus.resp_byteenable; o.op = bus.resp_lsu_op;
    o.exc = bus.resp_exc; o.ecause = bus.resp_ecause;
    l_ld = o.ldata; l_be = o.be; l_op = o.op; l_exc = o.exc; l_ec = o.ecause;
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    o.pulse_one = (bus.resp_valid === 1'b0) && (bus.req_ready === 1'b1) &&
                  (bus.resp_ldata === l_ld) && (bus.resp_byteenable === l_be) &&
                  (bus.resp_lsu_op === l_op) && (bus.resp_exc === l_exc) &&
                  (bus.resp_ecause === l_ec);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({bus.mem_valid, bus.resp_valid, bus.resp_exc, bus.mem_wstrb, bus.resp_byteenable} !== 11'h0) begin
      errors++;
      $display("FAIL reset_ctrl got mv=%b rv=%b exc=%b wstrb=%h be=%h want all 0",
               bus.mem_valid, bus.resp_valid, bus.resp_exc, bus.mem_wstrb, bus.resp_byteenable);
    end
    checks++;
    if ({bus.resp_ldata, bus.resp_ecause, bus.mem_addr, bus.mem_wdata, bus.resp_lsu_op} !== '0) begin
      errors++;
      $display("FAIL reset_data got ld=%h ec=%h ma=%h mw=%h op=%h want all 0",
               bus.resp_ldata, bus.resp_ecause, bus.mem_addr, bus.mem_wdata, bus.resp_lsu_op);
    end
    reset_n = 1'b1;
    @(posedge clock); @(negedge clock);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b want 1", bus.req_ready);
    end
  endtask

  task automatic test_lw();
    obs_t o;
    run_access(2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, o);
    checks++;
    if (o.timeout || o.maddr !== 32'h100 || o.mwstrb !== 4'h0 || o.lat != 2) begin
      errors++;
      $display("FAIL lw_mem got to=%0d ma=%h wstrb=%h lat=%0d want ma=100 wstrb=0 lat=2",
               o.timeout, o.maddr, o.mwstrb, o.lat);
    end
    checks++;
    if (o.be !== 4'hF || o.ldata !== 32'hDEADBEEF || o.op !== mk_op(2) || o.exc !== 1'b0 || !o.pulse_one) begin
      errors++;
      $display("FAIL lw_resp got be=%h ld=%h op=%h exc=%b pulse=%0d want be=f ld=deadbeef op=%h exc=0 pulse=1",
               o.be, o.ldata, o.op, o.exc, o.pulse_one, mk_op(2));
    end
  endtask

  task automatic test_sb();
    obs_t o;
    run_access(5, 32'h203, 32'h000000A5, 32'h55555555, 0, 0, o);
    checks++;
    if (o.timeout || o.maddr !== 32'h200 || o.mwdata !== 32'hA5A5A5A5 || o.mwstrb !== 4'h8) begin
      errors++;
      $display("FAIL sb_mem got ma=%h mw=%h wstrb=%h want 200 a5a5a5a5 8", o.maddr, o.mwdata, o.mwstrb);
    end
    checks++;
    if (o.be !== 4'h8 || o.ldata !== 32'h0) begin
      errors++; $display("FAIL sb_resp got be=%h ld=%h want 8 0", o.be, o.ldata);
    end
  endtask

  task automatic test_sh_wait();
    obs_t o;
    run_access(6, 32'h302, 32'h00001234, 32'h0, 3, 1, o);
    checks++;
    if (o.timeout || o.mwdata !== 32'h12341234 || o.mwstrb !== 4'hC || !o.stable || o.mem_cycles != 4) begin
      errors++;
      $display("FAIL sh_wait_mem got mw=%h wstrb=%h stable=%0d mcyc=%0d want 12341234 c 1 4",
               o.mwdata, o.mwstrb, o.stable, o.mem_cycles);
    end
    checks++;
    if (!o.ready_low || o.lat != 5 || !o.pulse_one) begin
      errors++;
      $display("FAIL sh_wait_ctrl got ready_low=%0d lat=%0d pulse=%0d want 1 5 1", o.ready_low, o.lat, o.pulse_one);
    end
  endtask

  task automatic test_misalign();
    obs_t o;
    run_access(1, 32'h401, 32'h0, 32'hCAFEF00D, 0, 0, o);
`ifdef MISALIGN_EXC_EN
    checks++;
    if (o.timeout || o.mem_cycles != 0 || o.lat != 1) begin
      errors++; $display("FAIL misalign_path got mcyc=%0d lat=%0d want 0 1", o.mem_cycles, o.lat);
    end
    checks++;
    if (o.exc !== 1'b1 || o.ecause !== 4'd4 || o.be !== 4'h0 || o.ldata !== 32'h0 || !o.pulse_one) begin
      errors++;
      $display("FAIL misalign_resp got exc=%b ec=%0d be=%h ld=%h pulse=%0d want 1 4 0 0 1",
               o.exc, o.ecause, o.be, o.ldata, o.pulse_one);
    end
`else
    checks++;
    if (o.timeout || o.maddr !== 32'h400 || o.be !== 4'h3 || o.ldata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL misalign_trunc got ma=%h be=%h ld=%h want 400 3 cafef00d", o.maddr, o.be, o.ldata);
    end
    checks++;
    if (o.exc !== 1'b0 || o.ecause !== 4'h0) begin
      errors++; $display("FAIL misalign_noexc got exc=%b ec=%h want 0 0", o.exc, o.ecause);
    end
`endif
  endtask

  task automatic test_reset_busy();
    obs_t o;
    bus.req_valid = 1'b1; bus.req_addr = 32'h500; bus.req_wdata = 32'h77; bus.req_lsu_op = mk_op(7);
    @(posedge clock); @(negedge clock);
    bus.req_valid = 1'b0; bus.mem_ready = 1'b0;
    checks++;
    if (bus.mem_valid !== 1'b1) begin
      errors++; $display("FAIL rstbusy_pre got mem_valid=%b want 1", bus.mem_valid);
    end
    @(posedge clock); @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock); @(negedge clock);
    checks++;
    if (bus.mem_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstbusy_drop got mv=%b rdy=%b rv=%b want 0 1 0", bus.mem_valid, bus.req_ready, bus.resp_valid);
    end
    reset_n = 1'b1;
    run_access(3, 32'h602, 32'h0, 32'h11223344, 1, 0, o);
    checks++;
    if (o.timeout || o.maddr !== 32'h600 || o.be !== 4'h4 || o.ldata !== 32'h11223344 ||
        o.op !== mk_op(3) || o.lat != 3 || !o.pulse_one) begin
      errors++;
      $display("FAIL rstbusy_lbu got ma=%h be=%h ld=%h lat=%0d pulse=%0d want 600 4 11223344 3 1",
               o.maddr, o.be, o.ldata, o.lat, o.pulse_one);
    end
  endtask

  task automatic test_random();
    obs_t o;
    int k, d, e_lat, e_mc;
    bit trap, st;
    logic [31:0] a, w, rd, e_ld;
    logic [3:0]  e_be, e_ec;
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 7); a = $urandom; w = $urandom; rd = $urandom;
      d = $urandom_range(0, 3);
      run_access(k, a, w, rd, d, ($urandom_range(0, 1) == 1), o);
      trap  = model_trap(k, a);
      st    = op_store(k);
      e_lat = trap ? 1 : 2 + d;
      e_mc  = trap ? 0 : d + 1;
      e_be  = trap ? 4'h0 : model_be(k, a);
      e_ld  = (trap || st) ? 32'h0 : rd;
      e_ec  = trap ? (st ? 4'd6 : 4'd4) : 4'd0;
      checks++;
      if (o.timeout || o.lat != e_lat || o.mem_cycles != e_mc || !o.ready_low || !o.pulse_one) begin
        errors++;
        $display("FAIL rand_timing[%0d] op=%0d a=%h got to=%0d lat=%0d mcyc=%0d rl=%0d pulse=%0d want lat=%0d mcyc=%0d",
                 i, k, a, o.timeout, o.lat, o.mem_cycles, o.ready_low, o.pulse_one, e_lat, e_mc);
      end
      if (!trap) begin
        checks++;
        if (o.maddr !== (a & 32'hFFFF_FFFC) || o.mwstrb !== (st ? e_be : 4'h0) || !o.stable ||
            (st && o.mwdata !== model_wdata(k, w))) begin
          errors++;
          $display("FAIL rand_mem[%0d] op=%0d a=%h got ma=%h mw=%h wstrb=%h stable=%0d want ma=%h mw=%h wstrb=%h",
                   i, k, a, o.maddr, o.mwdata, o.mwstrb, o.stable, a & 32'hFFFF_FFFC,
                   model_wdata(k, w), st ? e_be : 4'h0);
        end
      end
      checks++;
      if (o.ldata !== e_ld || o.be !== e_be || o.op !== mk_op(k) || o.exc !== trap || o.ecause !== e_ec) begin
        errors++;
        $display("FAIL rand_resp[%0d] op=%0d a=%h got ld=%h be=%h op=%h exc=%b ec=%0d want ld=%h be=%h op=%h exc=%b ec=%0d",
                 i, k, a, o.ldata, o.be, o.op, o.exc, o.ecause, e_ld, e_be, mk_op(k), trap, e_ec);
      end
    end
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.req_lsu_op = '0;
    bus.mem_ready  = 1'b0;
    bus.mem_rdata  = 32'h0;
    test_reset();
    test_lw();
    test_sb();
    test_sh_wait();
    test_misalign();
    test_reset_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
